store_drain_queue: RTL and testbench
====================================

Name: store_drain_queue

Overview:
- Shares the single data-memory write port (we/wa/wd/wm) between the two store pipes of the core.
- Stores from both pipes are captured in program order into a small circular queue. The queue retires one entry per cycle to the memory write port.
- Pending (not yet written) store data is forwarded to the two data-load ports, so loads never observe stale memory.

Parameters:
DEPTH, 4, number of queue entries (power of two, >= 2)
DEPTH_LOG, 2, log2(DEPTH); width of head/tail pointers

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
st_valid[2]  input  bool  store request from pipe 0 / pipe 1; pipe 0 is older in program order
st_addr[2]  input  32  store byte address
st_data[2]  input  32  store data word
st_mode[2]  input  ldst_mode_t  store mode, carried unchanged to wm
st_ready  output  bool  queue can accept two stores this cycle
ld_addr[2]  input  32  addresses currently presented on the two data read ports
ld_hit[2]  output  bool  pending store matches ld_addr[i]
ld_data[2]  output  32  forwarded word, valid when ld_hit[i] == true
we  output  bool  memory write enable
wa  output  32  memory write address
wd  output  32  memory write data
wm  output  ldst_mode_t  memory write mode
count  output  DEPTH_LOG+1  number of occupied entries
empty  output  bool  count == 0 (drain/fence indicator)

Behaviour:
- Async reset (rst_n low): count=0, head=tail=0, all entry valid bits cleared, we=false, wa=wd=0. Pending stores are discarded; reset mid-drain loses them by design.
- Release of reset is sampled on the next clk edge only.
- st_ready = (count <= DEPTH-2), computed combinationally from the registered count. It does not depend on st_valid or on a same-cycle drain (conservative).
- Enqueue:
  - A store is accepted at the rising edge when st_valid[i]==true and st_ready==true.
  - If both pipes are valid, pipe 0 is written at tail and pipe 1 at tail+1.
  - If only pipe 1 is valid, it is written at tail.
  - tail advances by the number accepted, modulo DEPTH (wrap-around).
  - Valid requests while st_ready==false are ignored; the producer holds them.
- Drain:
  - we is combinational from the head entry. When count>0: we=true, wa/wd/wm = head entry.
  - The memory captures the write on the same edge where head advances by 1 (mod DEPTH) and the head valid bit clears.
  - When count==0: we=false, wa=wd=0. Drain throughput is one store per cycle with zero added latency.
- Count update: count' = count + accepted - (count>0 ? 1 : 0). Simultaneous enqueue of 2 and drain of 1 is legal. count never exceeds DEPTH.
- empty = (count==0), combinational.
- Forwarding:
  - For each load port i, compare ld_addr[i][31:2] against addr[31:2] of every valid entry, including the head entry being written this cycle.
  - On any match: ld_hit[i]=true, and ld_data[i] is the data of the youngest matching entry (closest to tail).
  - No match: ld_hit[i]=false, ld_data[i]=0.
  - Stores presented on st_* in the same cycle are not visible to forwarding.
  - Byte offset and mode are ignored; forwarding is full-word, consistent with the memory's word writes.
- Ordering: memory writes occur in strict program order (pipe 0 before pipe 1, older cycles first). Two stores to the same word retire in order, so the last writer wins in memory.

Test Plan:
- Reset, then idle -> count=0, empty=true, we=false, st_ready=true. Assert rst_n low mid-drain with count=3 -> next cycle count=0, we=false, no further writes.
- Single store pipe0 addr=0x10, data=0xAAAA0001 -> next cycle we=true, wa=0x10, wd=0xAAAA0001. The following cycle count=0 and we=false.
- Dual store, pipe0 addr=0x20 data=1, pipe1 addr=0x24 data=2 -> writes appear in consecutive cycles, 0x20 then 0x24. count goes 2 then 1 then 0.
- Fill: dual stores every cycle for 3 cycles -> count reaches 3 (2, 3, ...), st_ready drops when count=3. Held requests are accepted once count<=2. Total 6 writes emitted in order, with head/tail wrap verified.
- Forwarding youngest:
  - Enqueue 0x30=0x11 then 0x30=0x22, with ld_addr[0]=0x32 -> ld_hit[0]=true, ld_data[0]=0x22.
  - ld_addr[1]=0x34 -> ld_hit[1]=false, ld_data[1]=0.
  - After both retire, ld_hit[0]=false.
- Same-cycle store/load, pipe0 store 0x40 while ld_addr[0]=0x40 with queue empty -> ld_hit[0]=false that cycle, true the next cycle.

Source files
------------

// File: rtl/store_drain_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_drain_queue_if
//  Brief    : Store, load-forward and memory-write bundle for store_drain_queue.
//  Revision : 1.0
// ============================================================================
interface store_drain_queue_if #(
    parameter int DEPTH_LOG = 2,
    parameter int MODE_W    = 3
);
    logic [1:0]             st_valid;
    logic [1:0][31:0]       st_addr;
    logic [1:0][31:0]       st_data;
    logic [1:0][MODE_W-1:0] st_mode;
    logic                   st_ready;
    logic [1:0][31:0]       ld_addr;
    logic [1:0]             ld_hit;
    logic [1:0][31:0]       ld_data;
    logic                   we;
    logic [31:0]            wa;
    logic [31:0]            wd;
    logic [MODE_W-1:0]      wm;
    logic [DEPTH_LOG:0]     count;
    logic                   empty;

    modport master (
        output st_valid, st_addr, st_data, st_mode, ld_addr,
        input  st_ready, ld_hit, ld_data, we, wa, wd, wm, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_mode, ld_addr,
        output st_ready, ld_hit, ld_data, we, wa, wd, wm, count, empty
    );
endinterface
`default_nettype wire

// File: rtl/store_drain_queue.sv
`default_nettype none
// ============================================================================
//  Module   : store_drain_queue
//  Brief    : In-order store queue sharing one memory write port between two
//             store pipes, with youngest-match load forwarding.
//  Revision : 1.0
// ============================================================================
module store_drain_queue #(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2,
    parameter int MODE_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_drain_queue_if.slave   bus
);
    localparam int unsigned READY_MAX = DEPTH - 2;

    logic [31:0]          r_addr [DEPTH];
    logic [31:0]          r_data [DEPTH];
    logic [MODE_W-1:0]    r_mode [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;

    logic                 w_ready;
    logic                 w_acc0;
    logic                 w_acc1;
    logic                 w_drain;
    logic [DEPTH_LOG-1:0] w_slot1;
    logic [DEPTH_LOG:0]   w_num_acc;
    logic [DEPTH_LOG-1:0] w_age_idx [DEPTH];
    logic [DEPTH-1:0]     w_live;
    logic                 w_unused;

    // Conservative: two free slots are required regardless of what drains.
    assign w_ready   = (r_count <= (DEPTH_LOG+1)'(READY_MAX));
    assign w_acc0    = bus.st_valid[0] & w_ready;
    assign w_acc1    = bus.st_valid[1] & w_ready;
    assign w_drain   = (r_count != '0);
    assign w_slot1   = r_tail + DEPTH_LOG'(w_acc0);
    assign w_num_acc = (DEPTH_LOG+1)'(w_acc0) + (DEPTH_LOG+1)'(w_acc1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mode[i] <= '0;
            end
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_acc0) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= bus.st_addr[0];
                r_data[r_tail]  <= bus.st_data[0];
                r_mode[r_tail]  <= bus.st_mode[0];
            end
            if (w_acc1) begin
                r_valid[w_slot1] <= 1'b1;
                r_addr[w_slot1]  <= bus.st_addr[1];
                r_data[w_slot1]  <= bus.st_data[1];
                r_mode[w_slot1]  <= bus.st_mode[1];
            end
            r_tail  <= r_tail + w_num_acc[DEPTH_LOG-1:0];
            r_count <= r_count + w_num_acc - (DEPTH_LOG+1)'(w_drain);
        end
    end

    assign bus.st_ready = w_ready;
    assign bus.count    = r_count;
    assign bus.empty    = ~w_drain;
    assign bus.we       = w_drain;
    assign bus.wa       = w_drain ? r_addr[r_head] : '0;
    assign bus.wd       = w_drain ? r_data[r_head] : '0;
    assign bus.wm       = w_drain ? r_mode[r_head] : '0;

    // Entries listed oldest (age 0, the head) to youngest.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_age
            assign w_age_idx[k] = r_head + DEPTH_LOG'(k);
            assign w_live[k]    = r_valid[w_age_idx[k]] &&
                                  ((DEPTH_LOG+1)'(k) < r_count);
        end

        for (genvar p = 0; p < 2; p++) begin : g_port
            logic        w_hit;
            logic [31:0] w_fwd;

            // Scanning oldest to youngest lets the youngest match win.
            always_comb begin
                w_hit = 1'b0;
                w_fwd = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (w_live[k] &&
                        (r_addr[w_age_idx[k]][31:2] == bus.ld_addr[p][31:2])) begin
                        w_hit = 1'b1;
                        w_fwd = r_data[w_age_idx[k]];
                    end
                end
            end

            assign bus.ld_hit[p]  = w_hit;
            assign bus.ld_data[p] = w_fwd;
        end
    endgenerate

    assign w_unused = ^{bus.ld_addr[0][1:0], bus.ld_addr[1][1:0]};

endmodule
`default_nettype wire

// File: tb/tb_store_drain_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_drain_queue
//  Brief    : Scoreboard bench for store_drain_queue: expected writes queued at
//             acceptance, popped by a memory-port monitor.
//  Revision : 1.0
// ============================================================================
module tb_store_drain_queue;
    localparam int DEPTH     = 4;
    localparam int DEPTH_LOG = 2;
    localparam int MODE_W    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_drain_queue_if #(.DEPTH_LOG(DEPTH_LOG), .MODE_W(MODE_W)) bus();

    store_drain_queue #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .MODE_W(MODE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]       a;
        logic [31:0]       d;
        logic [MODE_W-1:0] m;
    } wr_t;

    wr_t sbq[$];
    wr_t mon_e;
    int  checks  = 0;
    int  errors  = 0;
    int  m_count = 0;
    bit  m_acc0  = 1'b0;
    bit  m_acc1  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; leaves the inputs settled.
    task automatic present(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic v1, input logic [31:0] a1, input logic [31:0] d1);
        bit rdy;
        bus.st_valid   = {v1, v0};
        bus.st_addr[0] = a0;
        bus.st_data[0] = d0;
        bus.st_mode[0] = d0[MODE_W-1:0];
        bus.st_addr[1] = a1;
        bus.st_data[1] = d1;
        bus.st_mode[1] = d1[MODE_W-1:0];
        #1;
        rdy = (m_count <= DEPTH - 2);
        chk("st_ready", {31'd0, bus.st_ready}, {31'd0, rdy});
        m_acc0 = v0 && rdy;
        m_acc1 = v1 && rdy;
        if (m_acc0) sbq.push_back('{a: a0, d: d0, m: d0[MODE_W-1:0]});
        if (m_acc1) sbq.push_back('{a: a1, d: d1, m: d1[MODE_W-1:0]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_count = m_count + int'(m_acc0) + int'(m_acc1) - ((m_count > 0) ? 1 : 0);
        m_acc0 = 1'b0;
        m_acc1 = 1'b0;
        bus.st_valid = '0;
        chk("count", {29'd0, bus.count}, m_count);
        chk("empty", {31'd0, bus.empty}, {31'd0, (m_count == 0)});
    endtask

    task automatic idle();
        present(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    // Holds a dual store until the queue takes it, as a producer would.
    task automatic send2(input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1);
        bit taken = 1'b0;
        for (int n = 0; n < 8 && !taken; n++) begin
            present(1'b1, a0, d0, 1'b1, a1, d1);
            taken = m_acc0;
            tick();
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL send2_timeout: store 0x%08h never accepted", a0);
        end
    endtask

    // Memory-port monitor: every write must match the oldest expected store.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.we) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: got wa=0x%08h wd=0x%08h expected none",
                             bus.wa, bus.wd);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("wa", bus.wa, mon_e.a);
                    chk("wd", bus.wd, mon_e.d);
                    chk("wm", {29'd0, bus.wm}, {29'd0, mon_e.m});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.st_valid = '0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_mode  = '0;
        bus.ld_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", {29'd0, bus.count}, 32'd0);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_we", {31'd0, bus.we}, 32'd0);
        chk("rst_ready", {31'd0, bus.st_ready}, 32'd1);
        chk("rst_wa", bus.wa, 32'd0);
        chk("rst_wd", bus.wd, 32'd0);
        idle();

        // Single store, then idle
        present(1'b1, 32'h10, 32'hAAAA0001, 1'b0, 32'd0, 32'd0);
        tick();
        chk("single_we", {31'd0, bus.we}, 32'd1);
        idle();
        chk("single_we_off", {31'd0, bus.we}, 32'd0);

        // Dual store: program order 0x20 then 0x24
        present(1'b1, 32'h20, 32'h1, 1'b1, 32'h24, 32'h2);
        tick();
        idle();
        idle();

        // Fill with back-pressure and wrap
        send2(32'h100, 32'h1001, 32'h104, 32'h1002);
        send2(32'h108, 32'h1003, 32'h10C, 32'h1004);
        chk("fill_count3", {29'd0, bus.count}, 32'd3);
        chk("fill_ready_low", {31'd0, bus.st_ready}, 32'd0);
        send2(32'h110, 32'h1005, 32'h114, 32'h1006);
        while (m_count > 0) idle();

        // Youngest-match forwarding
        bus.ld_addr[0] = 32'h32;
        bus.ld_addr[1] = 32'h34;
        present(1'b1, 32'h30, 32'h11, 1'b1, 32'h30, 32'h22);
        tick();
        chk("fwd_hit0", {31'd0, bus.ld_hit[0]}, 32'd1);
        chk("fwd_data0", bus.ld_data[0], 32'h22);
        chk("fwd_hit1", {31'd0, bus.ld_hit[1]}, 32'd0);
        chk("fwd_data1", bus.ld_data[1], 32'd0);
        bus.ld_addr[1] = 32'h30;
        #1;
        chk("fwd_hit1_b", {31'd0, bus.ld_hit[1]}, 32'd1);
        chk("fwd_data1_b", bus.ld_data[1], 32'h22);
        idle();
        chk("fwd_hit0_one_left", {31'd0, bus.ld_hit[0]}, 32'd1);
        chk("fwd_data0_one_left", bus.ld_data[0], 32'h22);
        idle();
        chk("fwd_hit0_retired", {31'd0, bus.ld_hit[0]}, 32'd0);
        chk("fwd_data0_retired", bus.ld_data[0], 32'd0);

        // Same-cycle store is invisible to forwarding
        bus.ld_addr[0] = 32'h40;
        present(1'b1, 32'h40, 32'hBEEF0040, 1'b0, 32'd0, 32'd0);
        chk("same_cycle_hit", {31'd0, bus.ld_hit[0]}, 32'd0);
        tick();
        chk("next_cycle_hit", {31'd0, bus.ld_hit[0]}, 32'd1);
        chk("next_cycle_data", bus.ld_data[0], 32'hBEEF0040);
        idle();

        // Reset mid-drain with three pending stores
        present(1'b1, 32'h50, 32'h5050, 1'b1, 32'h54, 32'h5454);
        tick();
        present(1'b1, 32'h58, 32'h5858, 1'b1, 32'h5C, 32'h5C5C);
        tick();
        chk("pre_reset_count", {29'd0, bus.count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", {29'd0, bus.count}, 32'd0);
        chk("mid_rst_we", {31'd0, bus.we}, 32'd0);
        chk("mid_rst_wa", bus.wa, 32'd0);
        sbq.delete();
        m_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("post_rst_we", {31'd0, bus.we}, 32'd0);
        idle();
        chk("post_rst_we2", {31'd0, bus.we}, 32'd0);

        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
